ddr3_assoc_cache: RTL and testbench

Parametrised N-way set-associative write-back line cache between the system bus and the DDR3 controller. It serves 256-bit line reads and byte-masked writes from local RAM on a hit, and on a miss evicts a victim (writing it back if dirty) and refills from DDR3. A flush command writes back every dirty line to DDR3 so the controller holds the current data for DMA or power-down.

---
 rtl/ddr3_assoc_cache_pkg.sv | 23 ++
 rtl/ddr3_assoc_cache_way_ram.sv | 35 +++
 rtl/ddr3_assoc_cache.sv | 256 +++++++++++++++++++++++++
 tb/tb_ddr3_assoc_cache.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr3_assoc_cache_pkg.sv
// rtl/ddr3_assoc_cache_pkg.sv - shared constants, state encoding and width helper for ddr3_assoc_cache
package ddr3_assoc_cache_pkg;

    localparam int LINE_BYTES = 32;
    localparam int ADDR_BITS  = 29;
    localparam int OFF_BITS   = 5;

    typedef enum logic [2:0] {
        S_INIT       = 3'd0,
        S_IDLE       = 3'd1,
        S_WB         = 3'd2,
        S_REFILL     = 3'd3,
        S_FLUSH_SCAN = 3'd4,
        S_FLUSH_WB   = 3'd5,
        S_END        = 3'd6
    } state_t;

    // Bits needed to hold values 0..value, never less than one.
    function automatic int get_width(input int value);
        return (value < 2) ? 1 : $clog2(value + 1);
    endfunction

endpackage

// File: rtl/ddr3_assoc_cache_way_ram.sv
// rtl/ddr3_assoc_cache_way_ram.sv - single-port line RAM for one way, byte write enable, write-first
module ddr3_cache_way_ram
    import ddr3_assoc_cache_pkg::*;
#(
    parameter int DEPTH = 512,
    parameter int AW    = 9
) (
    input  logic                    clk,
    input  logic                    i_en,
    input  logic [LINE_BYTES-1:0]   i_be,
    input  logic [AW-1:0]           i_addr,
    input  logic [8*LINE_BYTES-1:0] i_wdata,
    output logic [8*LINE_BYTES-1:0] o_rdata
);

    logic [8*LINE_BYTES-1:0] r_mem [DEPTH];
    logic [8*LINE_BYTES-1:0] r_q;

    // Output holds while disabled so write-back data stays stable.
    always_ff @(posedge clk) begin
        if (i_en) begin
            for (int b = 0; b < LINE_BYTES; b++) begin
                if (i_be[b]) begin
                    r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
                    r_q[8*b +: 8]           <= i_wdata[8*b +: 8];
                end else begin
                    r_q[8*b +: 8]           <= r_mem[i_addr][8*b +: 8];
                end
            end
        end
    end

    assign o_rdata = r_q;

endmodule

// File: rtl/ddr3_assoc_cache.sv
// rtl/ddr3_assoc_cache.sv - N-way set-associative write-back line cache in front of the DDR3 controller
module ddr3_assoc_cache
    import ddr3_assoc_cache_pkg::*;
#(
    parameter int CACHE_SETS = 512,
    parameter int WAYS       = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          addr_i,
    input  logic [255:0]         data_i,
    input  logic [31:0]          sel_i,
    input  logic                 we_i,
    input  logic                 rd_i,
    output logic [255:0]         data_o,
    output logic                 ack_o,
    input  logic                 flush_i,
    output logic                 flush_done_o,
    output logic [ADDR_BITS-1:0] ctrl_addr_o,
    output logic [255:0]         ctrl_data_o,
    input  logic [255:0]         ctrl_data_i,
    output logic                 ctrl_we_o,
    output logic                 ctrl_rd_o,
    input  logic                 ctrl_ack_i
);

    localparam int SET_BITS = get_width(CACHE_SETS - 1);
    localparam int WAY_BITS = get_width(WAYS - 1);
    localparam int TAG_BITS = ADDR_BITS - OFF_BITS - SET_BITS;

    state_t r_state, w_next;

    logic [TAG_BITS-1:0] r_tag   [CACHE_SETS][WAYS];
    logic                r_valid [CACHE_SETS][WAYS];
    logic                r_dirty [CACHE_SETS][WAYS];
    logic [WAY_BITS-1:0] r_ptr   [CACHE_SETS];

    logic [SET_BITS-1:0]  r_set, r_scan_set;
    logic [WAY_BITS-1:0]  r_way, r_scan_way;
    logic [TAG_BITS-1:0]  r_req_tag;
    logic                 r_is_wr, r_flush_pending, r_flush_done;
    logic [ADDR_BITS-1:0] r_ctrl_addr;

    logic [SET_BITS-1:0]   w_req_set;
    logic [TAG_BITS-1:0]   w_req_tag;
    logic                  w_req, w_full_wr, w_hit, w_inv, w_vic_dirty;
    logic                  w_scan_last, w_scan_dirty, w_unused_addr;
    logic [WAY_BITS-1:0]   w_hit_way, w_inv_way, w_vic_way;
    logic [255:0]          w_merge, w_ram_wdata;
    logic [255:0]          w_rdata [WAYS];
    logic [LINE_BYTES-1:0] w_ram_be [WAYS];
    logic [WAYS-1:0]       w_ram_en;
    logic [SET_BITS-1:0]   w_ram_addr;

    assign w_req_set     = addr_i[SET_BITS+OFF_BITS-1:OFF_BITS];
    assign w_req_tag     = addr_i[ADDR_BITS-1:SET_BITS+OFF_BITS];
    assign w_unused_addr = ^{addr_i[31:ADDR_BITS], addr_i[OFF_BITS-1:0]};
    assign w_req         = rd_i | we_i;
    assign w_full_wr     = we_i & (&sel_i);
    assign w_scan_last   = (r_scan_set == SET_BITS'(CACHE_SETS - 1)) && (r_scan_way == WAY_BITS'(WAYS - 1));
    assign w_scan_dirty  = r_dirty[r_scan_set][r_scan_way];

    // Descending scan so the lowest matching / invalid way wins.
    always_comb begin
        w_hit     = 1'b0;
        w_hit_way = '0;
        w_inv     = 1'b0;
        w_inv_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (r_valid[w_req_set][w] && (r_tag[w_req_set][w] == w_req_tag)) begin
                w_hit     = 1'b1;
                w_hit_way = WAY_BITS'(w);
            end
            if (!r_valid[w_req_set][w]) begin
                w_inv     = 1'b1;
                w_inv_way = WAY_BITS'(w);
            end
        end
        w_vic_way   = w_inv ? w_inv_way : r_ptr[w_req_set];
        w_vic_dirty = r_valid[w_req_set][w_vic_way] && r_dirty[w_req_set][w_vic_way];
    end

    always_comb begin
        for (int b = 0; b < LINE_BYTES; b++) begin
            w_merge[8*b +: 8] = (r_is_wr && sel_i[b]) ? data_i[8*b +: 8] : ctrl_data_i[8*b +: 8];
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_INIT:       if (ctrl_ack_i) w_next = S_IDLE;
            S_IDLE: begin
                if (w_req) begin
                    if (w_hit)            w_next = S_END;
                    else if (w_vic_dirty) w_next = S_WB;
                    else if (w_full_wr)   w_next = S_END;
                    else                  w_next = S_REFILL;
                end else if (r_flush_pending) begin
                    w_next = S_FLUSH_SCAN;
                end
            end
            S_WB:         if (ctrl_ack_i) w_next = S_REFILL;
            S_REFILL:     if (ctrl_ack_i) w_next = S_END;
            S_FLUSH_SCAN: begin
                if (w_scan_dirty)     w_next = S_FLUSH_WB;
                else if (w_scan_last) w_next = S_IDLE;
            end
            S_FLUSH_WB:   if (ctrl_ack_i) w_next = w_scan_last ? S_IDLE : S_FLUSH_SCAN;
            S_END:        w_next = S_IDLE;
            default:      w_next = S_INIT;
        endcase
    end

    always_comb begin
        w_ram_addr  = r_set;
        w_ram_en    = '0;
        w_ram_wdata = w_merge;
        for (int w = 0; w < WAYS; w++) w_ram_be[w] = '0;
        case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    w_ram_addr  = w_req_set;
                    w_ram_en    = '1;
                    w_ram_wdata = data_i;
                    if (w_hit && we_i)                         w_ram_be[w_hit_way] = sel_i;
                    else if (!w_hit && !w_vic_dirty && w_full_wr) w_ram_be[w_vic_way] = '1;
                end
            end
            S_REFILL: begin
                if (ctrl_ack_i) begin
                    w_ram_en[r_way] = 1'b1;
                    w_ram_be[r_way] = '1;
                end
            end
            S_FLUSH_SCAN: begin
                w_ram_addr = r_scan_set;
                w_ram_en   = '1;
            end
            default: ;
        endcase
    end

    for (genvar g = 0; g < WAYS; g++) begin : g_way
        ddr3_cache_way_ram #(.DEPTH(CACHE_SETS), .AW(SET_BITS)) u_ram (
            .clk     (clk),
            .i_en    (w_ram_en[g]),
            .i_be    (w_ram_be[g]),
            .i_addr  (w_ram_addr),
            .i_wdata (w_ram_wdata),
            .o_rdata (w_rdata[g])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_INIT;
        else     r_state <= w_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < CACHE_SETS; s++) begin
                r_ptr[s] <= '0;
                for (int w = 0; w < WAYS; w++) begin
                    r_tag[s][w]   <= '0;
                    r_valid[s][w] <= 1'b0;
                    r_dirty[s][w] <= 1'b0;
                end
            end
            r_set           <= '0;
            r_scan_set      <= '0;
            r_way           <= '0;
            r_scan_way      <= '0;
            r_req_tag       <= '0;
            r_is_wr         <= 1'b0;
            r_flush_pending <= 1'b0;
            r_flush_done    <= 1'b0;
            r_ctrl_addr     <= '0;
        end else begin
            r_flush_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        r_set     <= w_req_set;
                        r_req_tag <= w_req_tag;
                        r_is_wr   <= we_i;
                        if (w_hit) begin
                            r_way <= w_hit_way;
                            if (we_i) r_dirty[w_req_set][w_hit_way] <= 1'b1;
                        end else begin
                            r_way <= w_vic_way;
                            if (!w_inv) begin
                                r_ptr[w_req_set] <= (r_ptr[w_req_set] == WAY_BITS'(WAYS - 1)) ?
                                                    '0 : r_ptr[w_req_set] + 1'b1;
                            end
                            if (w_vic_dirty) begin
                                r_ctrl_addr <= {r_tag[w_req_set][w_vic_way], w_req_set, {OFF_BITS{1'b0}}};
                            end else if (w_full_wr) begin
                                r_tag[w_req_set][w_vic_way]   <= w_req_tag;
                                r_valid[w_req_set][w_vic_way] <= 1'b1;
                                r_dirty[w_req_set][w_vic_way] <= 1'b1;
                            end else begin
                                r_ctrl_addr <= {w_req_tag, w_req_set, {OFF_BITS{1'b0}}};
                            end
                        end
                    end else if (r_flush_pending) begin
                        r_flush_pending <= 1'b0;
                        r_scan_set      <= '0;
                        r_scan_way      <= '0;
                    end
                end
                S_WB: begin
                    if (ctrl_ack_i) begin
                        r_dirty[r_set][r_way] <= 1'b0;
                        r_ctrl_addr           <= {r_req_tag, r_set, {OFF_BITS{1'b0}}};
                    end
                end
                S_REFILL: begin
                    if (ctrl_ack_i) begin
                        r_tag[r_set][r_way]   <= r_req_tag;
                        r_valid[r_set][r_way] <= 1'b1;
                        r_dirty[r_set][r_way] <= r_is_wr;
                    end
                end
                S_FLUSH_SCAN, S_FLUSH_WB: begin
                    if (r_state == S_FLUSH_SCAN && w_scan_dirty) begin
                        r_way       <= r_scan_way;
                        r_ctrl_addr <= {r_tag[r_scan_set][r_scan_way], r_scan_set, {OFF_BITS{1'b0}}};
                    end else if (r_state == S_FLUSH_SCAN || ctrl_ack_i) begin
                        if (r_state == S_FLUSH_WB) r_dirty[r_scan_set][r_scan_way] <= 1'b0;
                        if (w_scan_last) begin
                            r_flush_done <= 1'b1;
                        end else if (r_scan_way == WAY_BITS'(WAYS - 1)) begin
                            r_scan_way <= '0;
                            r_scan_set <= r_scan_set + 1'b1;
                        end else begin
                            r_scan_way <= r_scan_way + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
            // Pending is cleared when a flush starts, so a pulse during the scan re-arms it.
            if (flush_i) r_flush_pending <= 1'b1;
        end
    end

    assign ack_o        = (r_state == S_END);
    assign ctrl_we_o    = (r_state == S_WB) || (r_state == S_FLUSH_WB);
    assign ctrl_rd_o    = (r_state == S_REFILL);
    assign ctrl_addr_o  = r_ctrl_addr;
    assign flush_done_o = r_flush_done;
    assign data_o       = w_rdata[r_way];
    assign ctrl_data_o  = w_rdata[r_way];

endmodule

// File: tb/tb_ddr3_assoc_cache.sv
// tb/tb_ddr3_assoc_cache.sv - directed self-checking bench for ddr3_assoc_cache (4 sets, 2 ways)
module tb_ddr3_assoc_cache;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  addr_i;
    logic [255:0] data_i;
    logic [31:0]  sel_i;
    logic         we_i, rd_i, flush_i;
    logic [255:0] data_o, ctrl_data_o, ctrl_data_i;
    logic         ack_o, flush_done_o, ctrl_we_o, ctrl_rd_o, ctrl_ack_i;
    logic [28:0]  ctrl_addr_o;
    logic         ack_model, ack_cal;

    assign ctrl_ack_i = ack_model | ack_cal;

    always #5 clk = ~clk;

    ddr3_assoc_cache #(.CACHE_SETS(4), .WAYS(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .addr_i       (addr_i),
        .data_i       (data_i),
        .sel_i        (sel_i),
        .we_i         (we_i),
        .rd_i         (rd_i),
        .data_o       (data_o),
        .ack_o        (ack_o),
        .flush_i      (flush_i),
        .flush_done_o (flush_done_o),
        .ctrl_addr_o  (ctrl_addr_o),
        .ctrl_data_o  (ctrl_data_o),
        .ctrl_data_i  (ctrl_data_i),
        .ctrl_we_o    (ctrl_we_o),
        .ctrl_rd_o    (ctrl_rd_o),
        .ctrl_ack_i   (ctrl_ack_i)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] mdl_pat(input logic [28:0] a);
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[32*i +: 32] = {3'b000, a} ^ (32'h9E37_79B9 * (i + 1));
        return r;
    endfunction

    // DDR3 model: acks three cycles into a request, logs every transaction.
    logic [255:0] mdl_mem [logic [28:0]];
    bit           log_we   [$];
    logic [28:0]  log_addr [$];
    logic [255:0] log_data [$];
    int           overlap_err = 0;
    int           stab_err    = 0;

    initial begin
        int           cnt;
        logic [28:0]  a0;
        logic [255:0] d0;
        cnt = 0;
        ack_model = 1'b0;
        ctrl_data_i = '0;
        forever begin
            @(posedge clk);
            #1;
            if (ctrl_we_o && ctrl_rd_o) overlap_err++;
            if (rst) begin
                cnt = 0;
                ack_model = 1'b0;
            end else if (ack_model) begin
                ack_model = 1'b0;
                cnt = 0;
            end else if (ctrl_we_o || ctrl_rd_o) begin
                cnt++;
                if (cnt == 1) begin
                    a0 = ctrl_addr_o;
                    d0 = ctrl_data_o;
                end
                if (cnt == 3) begin
                    if (ctrl_addr_o !== a0 || (ctrl_we_o && ctrl_data_o !== d0)) stab_err++;
                    log_we.push_back(ctrl_we_o);
                    log_addr.push_back(ctrl_addr_o);
                    if (ctrl_we_o) begin
                        mdl_mem[ctrl_addr_o] = ctrl_data_o;
                        log_data.push_back(ctrl_data_o);
                    end else begin
                        ctrl_data_i = mdl_mem.exists(ctrl_addr_o) ? mdl_mem[ctrl_addr_o] : mdl_pat(ctrl_addr_o);
                        log_data.push_back(ctrl_data_i);
                    end
                    ack_model = 1'b1;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    int           lat, ack_at, ack_we_at, rd_first, we_first, done_at;
    logic [255:0] rdata;
    bit           got_ack;

    task automatic do_req(input bit wr, input logic [31:0] a, input logic [255:0] d,
                          input logic [31:0] s, input bit fl);
        @(negedge clk);
        addr_i = a; data_i = d; sel_i = s; we_i = wr; rd_i = !wr; flush_i = fl;
        lat = 0; ack_at = -1; ack_we_at = -1; rd_first = -1; we_first = -1; done_at = -1;
        got_ack = 1'b0;
        while (!got_ack && lat < 100) begin
            @(negedge clk);
            flush_i = 1'b0;
            lat++;
            if (ctrl_ack_i) ack_at = lat;
            if (ctrl_ack_i && ctrl_we_o) ack_we_at = lat;
            if (ctrl_rd_o && rd_first < 0) rd_first = lat;
            if (ctrl_we_o && we_first < 0) we_first = lat;
            if (flush_done_o && done_at < 0) done_at = lat;
            if (ack_o) begin
                got_ack = 1'b1;
                rdata = data_o;
            end
        end
        we_i = 1'b0; rd_i = 1'b0;
        chk("ack_seen", got_ack, 1'b1);
    endtask

    task automatic calibrate();
        @(negedge clk); ack_cal = 1'b1;
        @(negedge clk); ack_cal = 1'b0;
    endtask

    task automatic log_clear();
        log_we.delete(); log_addr.delete(); log_data.delete();
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] e20, e60, d0, d1, d2, e;
        int n;
        rst = 1'b1; addr_i = '0; data_i = '0; sel_i = '0; we_i = 1'b0; rd_i = 1'b0;
        flush_i = 1'b0; ack_cal = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outs", {ack_o, flush_done_o, ctrl_we_o, ctrl_rd_o, ctrl_addr_o}, '0);
        rst = 1'b0;
        calibrate();

        // Cold read: clean miss, refill.
        log_clear();
        do_req(1'b0, 32'h0000_0000, '0, '0, 1'b0);
        chk("rd0_data", rdata, mdl_pat(29'h0));
        chk("rd0_ack_after_ctrl_ack", lat, ack_at + 1);
        chk("rd0_ctrl_rd_rise", rd_first, 1);
        chk("rd0_ddr_txn", {log_we.size(), log_we[0], log_addr[0]}, {32'd1, 1'b0, 29'h0});

        log_clear();
        do_req(1'b0, 32'h0000_0000, '0, '0, 1'b0);
        chk("rd0_hit_lat", lat, 1);
        chk("rd0_hit_data", rdata, mdl_pat(29'h0));
        chk("rd0_hit_no_ddr", log_we.size(), 0);

        // Partial writes: refill, then merge.
        e20 = mdl_pat(29'h20); e20[7:0] = 8'hAB;
        do_req(1'b1, 32'h0000_0020, {{31{8'hFF}}, 8'hAB}, 32'h0000_0001, 1'b0);
        chk("wr20_merge", rdata, e20);
        chk("wr20_ack_after_ctrl_ack", lat, ack_at + 1);
        log_clear();
        do_req(1'b0, 32'h0000_0020, '0, '0, 1'b0);
        chk("rd20_hit", {lat, rdata}, {32'd1, e20});

        e60 = mdl_pat(29'h60); e60[63:32] = 32'h1111_1111;
        do_req(1'b1, 32'h0000_0060, {32{8'h11}}, 32'h0000_00F0, 1'b0);
        chk("wr60_merge", rdata, e60);

        // Flush with dirty lines in sets 1 and 3.
        log_clear();
        @(negedge clk); flush_i = 1'b1;
        @(negedge clk); flush_i = 1'b0;
        n = 0;
        while (!flush_done_o && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("flush_done", flush_done_o, 1'b1);
        @(negedge clk);
        chk("flush_done_pulse", flush_done_o, 1'b0);
        chk("flush_txn_count", log_we.size(), 2);
        chk("flush_wb0", {log_we[0], log_addr[0], log_data[0]}, {1'b1, 29'h20, e20});
        chk("flush_wb1", {log_we[1], log_addr[1], log_data[1]}, {1'b1, 29'h60, e60});
        log_clear();
        do_req(1'b0, 32'h0000_0020, '0, '0, 1'b0);
        chk("post_flush_rd20", {lat, rdata}, {32'd1, e20});
        do_req(1'b0, 32'h0000_0060, '0, '0, 1'b0);
        chk("post_flush_rd60", {lat, rdata}, {32'd1, e60});
        chk("post_flush_no_ddr", log_we.size(), 0);

        // Three tags into set 0: the third access evicts dirty way 0 (tag 0).
        d0 = {8{32'hD0D0_0000}}; d1 = {8{32'hD1D1_1111}}; d2 = {8{32'hD2D2_2222}};
        do_req(1'b1, 32'h0000_0000, d0, 32'hFFFF_FFFF, 1'b0);
        chk("wr000_hit", {lat, rdata}, {32'd1, d0});
        do_req(1'b1, 32'h0000_0080, d1, 32'hFFFF_FFFF, 1'b0);
        chk("wr080_install", {lat, rdata}, {32'd1, d1});
        chk("wr080_no_ddr", log_we.size(), 0);
        do_req(1'b1, 32'h0000_0100, d2, 32'hFFFF_FFFF, 1'b0);
        chk("wr100_data", rdata, d2);
        chk("wr100_wb", {log_we[0], log_addr[0], log_data[0]}, {1'b1, 29'h000, d0});
        chk("wr100_refill", {log_we[1], log_addr[1]}, {1'b0, 29'h100});
        chk("wr100_we_rise", we_first, 1);
        chk("wr100_rd_after_wb", rd_first, ack_we_at + 1);
        chk("wr100_ack_after_ctrl_ack", lat, ack_at + 1);
        do_req(1'b0, 32'h0000_0080, '0, '0, 1'b0);
        chk("rd080_hit", {lat, rdata}, {32'd1, d1});

        // Reset in the middle of a refill discards the cache contents.
        @(negedge clk); addr_i = 32'h0000_0200; rd_i = 1'b1;
        n = 0;
        while (!ctrl_rd_o && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("refill_reached", ctrl_rd_o, 1'b1);
        rst = 1'b1;
        #1;
        chk("rst_mid_refill_outs", {ack_o, flush_done_o, ctrl_we_o, ctrl_rd_o, ctrl_addr_o}, '0);
        rd_i = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        calibrate();
        log_clear();
        do_req(1'b0, 32'h0000_0100, '0, '0, 1'b0);
        chk("post_rst_miss", {rd_first, log_we[0], log_addr[0]}, {32'd1, 1'b0, 29'h100});
        chk("post_rst_data", rdata, mdl_pat(29'h100));

        // Request and flush together: read first, then an eight-entry clean scan.
        log_clear();
        do_req(1'b0, 32'h0000_0100, '0, '0, 1'b1);
        chk("rd_before_flush_lat", lat, 1);
        while (done_at < 0 && lat < 100) begin
            @(negedge clk);
            lat++;
            if (flush_done_o) done_at = lat;
        end
        chk("flush_after_read", done_at, 11);
        chk("clean_flush_no_ddr", log_we.size(), 0);

        chk("ctrl_we_rd_overlap", overlap_err, 0);
        chk("ctrl_stability", stab_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
